// File: rtl/act_pipe_arr.sv
// act_pipe_arr: two-stage pipelined activation array.
// Each beat carries LANES signed lanes, plus the mode, clip bound and lane mask
// that were present when it was accepted. The result is registered in the
// second stage. A saturating counter tracks how many zero lanes are delivered.
module act_pipe_arr #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 9,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  mode,
    input  logic [DATA_WIDTH-2:0]       clip_max,
    input  logic [LANES-1:0]            lane_en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    input  logic                        cnt_clr,
    output logic [CNT_WIDTH-1:0]        zero_count
);

    localparam int ZW = $clog2(LANES + 1);
    localparam int SW = CNT_WIDTH + ZW;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Stage 1: captured beat and its controls
    logic                        s1_valid_reg;
    logic [LANES*DATA_WIDTH-1:0] s1_data_reg;
    logic [1:0]                  s1_mode_reg;
    logic [DATA_WIDTH-2:0]       s1_clip_reg;
    logic [LANES-1:0]            s1_en_reg;

    // Stage 2: computed result
    logic                        s2_valid_reg;
    logic [LANES*DATA_WIDTH-1:0] s2_data_reg;

    logic [CNT_WIDTH-1:0]        zero_count_reg;
    logic [CNT_WIDTH-1:0]        zero_count_next;

    logic [LANES*DATA_WIDTH-1:0] result;
    logic [LANES-1:0]            zero_flag;
    logic [ZW-1:0]               zero_lanes;
    logic [SW-1:0]               cnt_sum;
    logic                        adv2;

    // S2 may advance when it is empty or its beat is being taken; S1 loads
    // whenever it is empty or able to hand its beat forward.
    assign adv2     = !s2_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || adv2;

    assign out_valid  = s2_valid_reg;
    assign out_data   = s2_data_reg;
    assign zero_count = zero_count_reg;

    // Stage 1 register: capture the beat together with the controls that apply to it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_mode_reg  <= 2'd0;
            s1_clip_reg  <= '0;
            s1_en_reg    <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_data_reg <= in_data;
                s1_mode_reg <= mode;
                s1_clip_reg <= clip_max;
                s1_en_reg   <= lane_en;
            end
        end
    end

    // Per-lane activation on the stage-1 beat
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] x;
            logic [DATA_WIDTH-1:0] y;
            logic                  x_neg;
            logic                  x_zero;

            assign x      = s1_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
            assign x_neg  = x[DATA_WIDTH-1];
            assign x_zero = ~|x;

            // Select the lane result; a masked lane always yields zero
            always_comb begin
                y = '0;
                if (s1_en_reg[gi]) begin
                    case (s1_mode_reg)
                        2'd0: y = x;
                        2'd1: y = (x_neg || x_zero) ? '0 : x;
                        2'd2: y = x_neg ? DATA_WIDTH'($signed(x) >>> LEAK_SHIFT) : x;
                        2'd3: begin
                            if (x_neg || x_zero)
                                y = '0;
                            else if (x[DATA_WIDTH-2:0] > s1_clip_reg)
                                y = {1'b0, s1_clip_reg};
                            else
                                y = x;
                        end
                        default: y = '0;
                    endcase
                end
            end

            assign result[gi*DATA_WIDTH +: DATA_WIDTH] = y;
            assign zero_flag[gi] = ~|s2_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Stage 2 register: hold the result while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
        end else if (adv2) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg)
                s2_data_reg <= result;
        end
    end

    // Count zero lanes of the beat on the output and saturate the sum
    always_comb begin
        zero_lanes = '0;
        for (int i = 0; i < LANES; i++)
            zero_lanes = zero_lanes + ZW'(zero_flag[i]);
        cnt_sum = SW'(zero_count_reg) + SW'(zero_lanes);
        zero_count_next = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_WIDTH-1:0];
    end

    // Zero counter: clear has priority over a counting handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            zero_count_reg <= '0;
        else if (cnt_clr)
            zero_count_reg <= '0;
        else if (s2_valid_reg && out_ready)
            zero_count_reg <= zero_count_next;
    end

endmodule

// File: tb/tb_act_pipe_arr.sv
// Scoreboard bench for act_pipe_arr (4 lanes, 4-bit counter).
// Accepted beats push their expected result; a negedge monitor pops and compares on each output handshake.
module tb_act_pipe_arr;

    localparam int DW = 16;
    localparam int LN = 4;
    localparam int LS = 3;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [1:0]         mode;
    logic [DW-2:0]      clip_max;
    logic [LN-1:0]      lane_en;
    logic               in_valid;
    logic               in_ready;
    logic [LN*DW-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [LN*DW-1:0]   out_data;
    logic               cnt_clr;
    logic [CW-1:0]      zero_count;

    act_pipe_arr #(
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .LEAK_SHIFT (LS),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .clip_max   (clip_max),
        .lane_en    (lane_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cnt_clr    (cnt_clr),
        .zero_count (zero_count)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    int          exp_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic [63:0] mon_e;
    int          mon_nz;
    int          rdy_mode = 0;
    logic        use_fixed = 1'b0;
    logic [63:0] fixed_exp = '0;
    logic [3:0]  pat = 4'b1001;
    int          pidx = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Reference: activation rules on plain integers
    function automatic logic [63:0] model(input logic [1:0] m, input logic [DW-2:0] c,
                                          input logic [LN-1:0] en, input logic [63:0] d);
        logic [63:0] r;
        int x, y, q, dv, cl;
        r  = '0;
        dv = 1 << LS;
        cl = int'(c);
        for (int i = 0; i < LN; i++) begin
            x = int'($signed(d[i*16 +: 16]));
            y = 0;
            if (en[i]) begin
                case (m)
                    2'd0: y = x;
                    2'd1: y = (x > 0) ? x : 0;
                    2'd2: begin
                        if (x >= 0) y = x;
                        else begin
                            q = x / dv;
                            if (q * dv != x) q = q - 1;
                            y = q;
                        end
                    end
                    default: y = (x <= 0) ? 0 : ((x > cl) ? cl : x);
                endcase
            end
            r[i*16 +: 16] = 16'(y);
        end
        return r;
    endfunction

    function automatic int zeros(input logic [63:0] d);
        int n = 0;
        for (int i = 0; i < LN; i++)
            if (d[i*16 +: 16] == 16'd0) n++;
        return n;
    endfunction

    function automatic logic [15:0] rand_lane();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            3: return 16'h8000;
            4: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 0;
            prev_stall = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_zero_count", zero_count, 0);
        end else begin
            chk("zero_count", zero_count, exp_cnt);
            chk("in_ready", in_ready, (exp_q.size() < 2 || out_ready));
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && exp_q.size() == 0)
                chk("spurious_out", out_valid, 0);
            mon_nz = 0;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("out_data", out_data, mon_e);
                mon_nz = zeros(mon_e);
            end
            if (cnt_clr)
                exp_cnt = 0;
            else if (out_valid && out_ready)
                exp_cnt = (exp_cnt + mon_nz > CMAX) ? CMAX : exp_cnt + mon_nz;
            if (in_valid && in_ready)
                exp_q.push_back(use_fixed ? fixed_exp : model(mode, clip_max, lane_en, in_data));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Downstream ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    out_ready = pat[pidx];
                    pidx = (pidx + 1) % 4;
                end
                3: out_ready = 1'b0;
                default: ;
            endcase
        end
    end

    task automatic send(input logic [1:0] m, input logic [DW-2:0] c,
                        input logic [LN-1:0] en, input logic [63:0] d);
        int tries = 0;
        logic acc = 1'b0;
        mode = m; clip_max = c; lane_en = en; in_data = d; in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
            if (!acc && tries > 300) begin
                chk("accept_timeout", acc, 1);
                break;
            end
        end
        in_valid = 1'b0;
        $display("beat mode=%0d en=%b data=%h", m, en, d);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; mode = 2'd0; clip_max = '0; lane_en = '0;
        in_data = '0; cnt_clr = 1'b0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_zero_count", zero_count, 0);
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", in_ready, 1);

        // ReLU with latency check
        use_fixed = 1'b1;
        fixed_exp = pack(5, 0, 0, 32767);
        send(2'd1, 15'd0, 4'b1111, pack(5, -3, 0, 32767));
        chk("latency_s1", out_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_s2", out_valid, 1);
        chk("relu_data", out_data, pack(5, 0, 0, 32767));
        drain();
        chk("relu_zero_count", zero_count, 2);

        // Leaky, clipped, masked bypass
        fixed_exp = pack(-2, -1, -4096, 7);
        send(2'd2, 15'd0, 4'b1111, pack(-16, -1, -32768, 7));
        fixed_exp = pack(100, 0, 100, 99);
        send(2'd3, 15'd100, 4'b1111, pack(150, -4, 100, 99));
        fixed_exp = pack(1, 0, 3, 0);
        send(2'd0, 15'd0, 4'b0101, pack(1, 2, 3, 4));
        drain();
        chk("directed_zero_count", zero_count, 5);
        use_fixed = 1'b0;

        // Per-beat mode change on identical data
        for (int m = 0; m < 4; m++)
            send(2'(m), 15'd100, 4'b1111, pack(-8, 8, -1, 200));
        drain();

        // Eight back-to-back beats with 1,0,0,1 ready pattern
        rdy_mode = 2;
        for (int i = 0; i < 8; i++)
            send(2'($urandom_range(0, 3)), 15'($urandom_range(0, 500)), 4'b1111,
                 {rand_lane(), rand_lane(), rand_lane(), rand_lane()});
        drain();

        // Random stream with random backpressure and clears
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            cnt_clr = ($urandom_range(0, 7) == 0);
            send(2'($urandom_range(0, 3)), 15'($urandom), 4'($urandom),
                 {rand_lane(), rand_lane(), rand_lane(), rand_lane()});
        end
        cnt_clr = 1'b0;
        drain();

        // Saturation at 15
        rdy_mode = 0;
        @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++)
            send(2'd0, 15'd0, 4'b0000, pack(9, 9, 9, 9));
        drain();
        chk("sat_zero_count", zero_count, 15);
        send(2'd1, 15'd0, 4'b1111, pack(0, 0, 1, 1));
        drain();
        chk("sat_hold", zero_count, 15);

        // Clear coinciding with a counting handshake
        rdy_mode = 4;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        send(2'd0, 15'd0, 4'b0000, pack(0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("clr_pending_valid", out_valid, 1);
        cnt_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_wins", zero_count, 0);
        chk("clr_beat_gone", out_valid, 0);

        // Reset in the middle of a stalled stream
        out_ready = 1'b1;
        send(2'd0, 15'd0, 4'b0000, pack(1, 1, 1, 1));
        drain();
        chk("pre_rst_count", zero_count, 4);
        out_ready = 1'b0;
        mode = 2'd0; lane_en = 4'b1111; in_data = pack(11, 22, 33, 44); in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("full_in_ready", in_ready, 0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_zero_count", zero_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        rdy_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_beat", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
